// File: rtl/gpio_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_pkg - register map and helpers shared by the iomem GPIO block       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package gpio_pkg;

  localparam logic [2:0] REG_OUT        = 3'd0;
  localparam logic [2:0] REG_IN         = 3'd1;
  localparam logic [2:0] REG_OUT_SET    = 3'd2;
  localparam logic [2:0] REG_OUT_CLR    = 3'd3;
  localparam logic [2:0] REG_IRQ_RISE   = 3'd4;
  localparam logic [2:0] REG_IRQ_FALL   = 3'd5;
  localparam logic [2:0] REG_IRQ_STATUS = 3'd6;
  localparam logic [2:0] REG_IRQ_EN     = 3'd7;

  localparam int         REG_COUNT       = 8;
  localparam logic [7:0] BASE_HI_DEFAULT = 8'h03;

  // Expand the four byte strobes into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] wstrb);
    return {{8{wstrb[3]}}, {8{wstrb[2]}}, {8{wstrb[1]}}, {8{wstrb[0]}}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gpio_in_cond.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | gpio_in_cond - input synchroniser, debouncer and edge detector           |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module gpio_in_cond #(
  parameter int W       = 16,
  parameter int DEB_DIV = 50000,
  parameter int DEB_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] gpio_in,
  output logic [W-1:0] in_db,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] r_sync1;
  logic [W-1:0] r_sync2;
  logic [W-1:0] r_prev;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      r_prev  <= in_db;
    end
  end

  generate
    if (DEB_DIV == 0) begin : g_bypass
      assign in_db = r_sync2;
    end else begin : g_debounce
      localparam logic [DEB_W-1:0] c_last = DEB_W'(DEB_DIV - 1);

      logic [DEB_W-1:0] r_presc;
      logic [W-1:0]     r_samp;
      logic [W-1:0]     r_db;
      logic             w_tick;
      logic [W-1:0]     w_agree;

      assign w_tick  = (r_presc == c_last);
      // A bit may only move once two successive tick samples agree.
      assign w_agree = ~(r_samp ^ r_sync2);

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_presc <= '0;
          r_samp  <= '0;
          r_db    <= '0;
        end else begin
          r_presc <= w_tick ? '0 : r_presc + 1'b1;
          if (w_tick) begin
            r_samp <= r_sync2;
            r_db   <= (r_db & ~w_agree) | (r_sync2 & w_agree);
          end
        end
      end

      assign in_db = r_db;
    end
  endgenerate

  assign rise = in_db & ~r_prev;
  assign fall = ~in_db & r_prev;

endmodule
`default_nettype wire

// File: rtl/iomem_gpio_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | iomem_gpio_irq - picosoc iomem GPIO with edge-capture level interrupt    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module iomem_gpio_irq
  import gpio_pkg::*;
#(
  parameter int         N_OUT   = 16,
  parameter int         N_IN    = 16,
  parameter logic [7:0] BASE_HI = BASE_HI_DEFAULT,
  parameter int         DEB_DIV = 50000,
  parameter int         DEB_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [N_IN-1:0]  gpio_in,
  output logic [N_OUT-1:0] gpio_out,
  output logic             irq
);

  logic             r_ready;
  logic [31:0]      r_rdata;
  logic [N_OUT-1:0] r_out;
  logic [N_IN-1:0]  r_rise_en;
  logic [N_IN-1:0]  r_fall_en;
  logic [N_IN-1:0]  r_status;
  logic [N_IN-1:0]  r_en;

  logic [N_IN-1:0]  w_in_db;
  logic [N_IN-1:0]  w_rise;
  logic [N_IN-1:0]  w_fall;

  logic             w_take;
  logic             w_wr;
  logic [2:0]       w_reg;
  logic [31:0]      w_bmask;
  logic [31:0]      w_wbits;
  logic [N_OUT-1:0] w_out_m;
  logic [N_OUT-1:0] w_out_d;
  logic [N_IN-1:0]  w_in_m;
  logic [N_IN-1:0]  w_in_d;
  logic [N_IN-1:0]  w_event;
  logic [N_IN-1:0]  w_clr;
  logic [31:0]      w_rd_val;
  logic             w_unused;

  gpio_in_cond #(
    .W       (N_IN),
    .DEB_DIV (DEB_DIV),
    .DEB_W   (DEB_W)
  ) u_in_cond (
    .clk     (clk),
    .reset   (reset),
    .gpio_in (gpio_in),
    .in_db   (w_in_db),
    .rise    (w_rise),
    .fall    (w_fall)
  );

  // The !r_ready term spaces accesses two cycles apart so one request acks once.
  assign w_take  = iomem_valid && !r_ready && (iomem_addr[31:24] == BASE_HI);
  assign w_wr    = w_take && (iomem_wstrb != 4'b0000);
  assign w_reg   = iomem_addr[$clog2(REG_COUNT)+1:2];
  assign w_bmask = byte_mask(iomem_wstrb);
  assign w_wbits = iomem_wdata & w_bmask;
  assign w_out_m = w_bmask[N_OUT-1:0];
  assign w_out_d = w_wbits[N_OUT-1:0];
  assign w_in_m  = w_bmask[N_IN-1:0];
  assign w_in_d  = w_wbits[N_IN-1:0];

  assign w_event = (w_rise & r_rise_en) | (w_fall & r_fall_en);
  assign w_clr   = (w_wr && (w_reg == REG_IRQ_STATUS)) ? w_in_d : '0;

  always_comb begin
    w_rd_val = '0;
    case (w_reg)
      REG_OUT:        w_rd_val = 32'(r_out);
      REG_IN:         w_rd_val = 32'(w_in_db);
      REG_IRQ_RISE:   w_rd_val = 32'(r_rise_en);
      REG_IRQ_FALL:   w_rd_val = 32'(r_fall_en);
      REG_IRQ_STATUS: w_rd_val = 32'(r_status);
      REG_IRQ_EN:     w_rd_val = 32'(r_en);
      default:        w_rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ready   <= 1'b0;
      r_rdata   <= '0;
      r_out     <= '0;
      r_rise_en <= '0;
      r_fall_en <= '0;
      r_status  <= '0;
      r_en      <= '0;
    end else begin
      r_ready <= w_take;
      if (w_take) begin
        r_rdata <= w_rd_val;
      end
      // Event set is applied after the clear so a coincident edge is never lost.
      r_status <= (r_status & ~w_clr) | w_event;
      if (w_wr) begin
        case (w_reg)
          REG_OUT:      r_out     <= (r_out & ~w_out_m) | w_out_d;
          REG_OUT_SET:  r_out     <= r_out | w_out_d;
          REG_OUT_CLR:  r_out     <= r_out & ~w_out_d;
          REG_IRQ_RISE: r_rise_en <= (r_rise_en & ~w_in_m) | w_in_d;
          REG_IRQ_FALL: r_fall_en <= (r_fall_en & ~w_in_m) | w_in_d;
          REG_IRQ_EN:   r_en      <= (r_en & ~w_in_m) | w_in_d;
          default: ;
        endcase
      end
    end
  end

  assign iomem_ready = r_ready;
  assign iomem_rdata = r_rdata;
  assign gpio_out    = r_out;
  assign irq         = |(r_status & r_en);

  assign w_unused = &{1'b0, iomem_addr, iomem_wdata, w_bmask};

endmodule
`default_nettype wire

// File: tb/tb_iomem_gpio_irq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_iomem_gpio_irq - directed self-checking bench, DEB_DIV=4              |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_iomem_gpio_irq;

  localparam logic [31:0] A_OUT    = 32'h0300_0000;
  localparam logic [31:0] A_IN     = 32'h0300_0004;
  localparam logic [31:0] A_SET    = 32'h0300_0008;
  localparam logic [31:0] A_CLR    = 32'h0300_000C;
  localparam logic [31:0] A_RISE   = 32'h0300_0010;
  localparam logic [31:0] A_FALL   = 32'h0300_0014;
  localparam logic [31:0] A_STATUS = 32'h0300_0018;
  localparam logic [31:0] A_EN     = 32'h0300_001C;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        iomem_valid = 1'b0;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb = 4'b0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic [15:0] gpio_in = '0;
  logic [15:0] gpio_out;
  logic        irq;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;

  iomem_gpio_irq #(
    .N_OUT   (16),
    .N_IN    (16),
    .BASE_HI (8'h03),
    .DEB_DIV (4),
    .DEB_W   (4)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .gpio_in     (gpio_in),
    .gpio_out    (gpio_out),
    .irq         (irq)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // lat = edges from valid to ready (-1 if no ack within 8 edges)
  task automatic bus(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                     output logic [31:0] rd, output int lat);
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = a; iomem_wstrb = s; iomem_wdata = d;
    lat = 0;
    do begin
      @(posedge clk); #1; lat++;
    end while (!iomem_ready && lat < 8);
    rd = iomem_rdata;
    acc_cyc = cyc;
    if (!iomem_ready) lat = -1;
    @(negedge clk);
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
  endtask

  task automatic test_reset;
    logic [31:0] rd; int lat;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    n_checks++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", iomem_ready); end
    bus(A_OUT, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_out_rd: got %h want 00000000", rd); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ack_latency: got %0d want 1", lat); end
    @(posedge clk); #1;
    n_checks++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL ack_one_cycle: got %b want 0", iomem_ready); end
    bus(A_IN, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_in_rd: got %h want 00000000", rd); end
    n_checks++; if (gpio_out !== 16'h0) begin n_fail++; $display("FAIL reset_gpio_out: got %h want 0000", gpio_out); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b want 0", irq); end
  endtask

  task automatic test_out;
    logic [31:0] rd; int lat;
    bus(A_OUT, 4'b0001, 32'hFFFF_A5A5, rd, lat);
    n_checks++; if (gpio_out !== 16'h00A5) begin n_fail++; $display("FAIL out_wstrb: got %h want 00a5", gpio_out); end
    bus(A_SET, 4'b1111, 32'h0000_0100, rd, lat);
    n_checks++; if (gpio_out !== 16'h01A5) begin n_fail++; $display("FAIL out_set: got %h want 01a5", gpio_out); end
    bus(A_CLR, 4'b1111, 32'h0000_0001, rd, lat);
    n_checks++; if (gpio_out !== 16'h01A4) begin n_fail++; $display("FAIL out_clr: got %h want 01a4", gpio_out); end
    bus(A_OUT, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0000_01A4) begin n_fail++; $display("FAIL out_read: got %h want 000001a4", rd); end
    bus(A_SET, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL wo_read: got %h want 00000000", rd); end
  endtask

  task automatic test_debounce;
    logic [31:0] rd; int lat; int c0;
    @(negedge clk); gpio_in[3] = 1'b1;
    repeat (3) @(negedge clk);
    gpio_in[3] = 1'b0;
    repeat (14) @(negedge clk);
    bus(A_IN, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL deb_glitch: got %h want 00000000", rd); end
    @(negedge clk); gpio_in[3] = 1'b1; c0 = cyc;
    rd = '0;
    for (int i = 0; i < 10; i++) begin
      bus(A_IN, 4'b0, 32'h0, rd, lat);
      if (rd == 32'h8) break;
    end
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL deb_settle: got %h want 00000008", rd); end
    n_checks++; if ((acc_cyc - c0) < 7 || (acc_cyc - c0) > 16) begin
      n_fail++; $display("FAIL deb_latency: got %0d cycles want 7..16", acc_cyc - c0);
    end
    @(negedge clk); gpio_in[3] = 1'b0;
    repeat (16) @(negedge clk);
    bus(A_IN, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL deb_fall: got %h want 00000000", rd); end
  endtask

  task automatic test_irq;
    logic [31:0] rd; int lat;
    bus(A_RISE, 4'b1111, 32'h8, rd, lat);
    bus(A_EN, 4'b1111, 32'h8, rd, lat);
    @(negedge clk); gpio_in[3] = 1'b1;
    repeat (16) @(negedge clk);
    bus(A_STATUS, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL rise_status: got %h want 00000008", rd); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL rise_irq: got %b want 1", irq); end
    bus(A_STATUS, 4'b0001, 32'h8, rd, lat);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL w1c_irq: got %b want 0", irq); end
    bus(A_STATUS, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL w1c_status: got %h want 00000000", rd); end
    bus(A_RISE, 4'b1111, 32'h0, rd, lat);
    bus(A_FALL, 4'b1111, 32'h8, rd, lat);
    @(negedge clk); gpio_in[3] = 1'b0;
    repeat (16) @(negedge clk);
    bus(A_STATUS, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL fall_status: got %h want 00000008", rd); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL fall_irq: got %b want 1", irq); end
    bus(A_EN, 4'b1111, 32'h0, rd, lat);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL mask_irq: got %b want 0", irq); end
    bus(A_EN, 4'b1111, 32'h8, rd, lat);
    bus(A_STATUS, 4'b0010, 32'h8, rd, lat);
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL w1c_wstrb: got %b want 1", irq); end
    bus(A_STATUS, 4'b0001, 32'h8, rd, lat);
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL fall_clear: got %b want 0", irq); end
  endtask

  task automatic test_set_wins;
    logic [31:0] rd; int lat; bit found;
    bus(A_FALL, 4'b1111, 32'h0, rd, lat);
    bus(A_RISE, 4'b1111, 32'h8, rd, lat);
    @(negedge clk); gpio_in[3] = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      @(negedge clk);
      if (dut.u_in_cond.rise[3]) found = 1'b1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL set_wins_edge: got no edge want edge within 30 cycles"); end
    // W1C lands on the same edge that captures the rising event
    iomem_valid = 1'b1; iomem_addr = A_STATUS; iomem_wstrb = 4'b0001; iomem_wdata = 32'h8;
    @(posedge clk); #1;
    @(negedge clk); iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    bus(A_STATUS, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h8) begin n_fail++; $display("FAIL set_wins: got %h want 00000008", rd); end
  endtask

  task automatic test_bad_addr;
    bit seen;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = 32'h0400_0000; iomem_wstrb = 4'b0;
    seen = 1'b0;
    repeat (5) begin
      @(posedge clk); #1;
      if (iomem_ready) seen = 1'b1;
    end
    n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bad_addr_ack: got %b want 0", seen); end
    @(negedge clk); iomem_valid = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd; int lat;
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL pre_reset_irq: got %b want 1", irq); end
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = A_OUT; iomem_wstrb = 4'b0011; iomem_wdata = 32'hFFFF;
    @(posedge clk); #1;
    n_checks++; if (iomem_ready !== 1'b1) begin n_fail++; $display("FAIL pending_ack: got %b want 1", iomem_ready); end
    reset = 1'b1;
    #1;
    n_checks++; if (iomem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_mid_ready: got %b want 0", iomem_ready); end
    n_checks++; if (gpio_out !== 16'h0) begin n_fail++; $display("FAIL reset_mid_out: got %h want 0000", gpio_out); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_mid_irq: got %b want 0", irq); end
    @(negedge clk); iomem_valid = 1'b0; iomem_wstrb = 4'b0; gpio_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus(A_OUT, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_out: got %h want 00000000", rd); end
    bus(A_RISE, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_rise: got %h want 00000000", rd); end
    bus(A_STATUS, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_status: got %h want 00000000", rd); end
    bus(A_EN, 4'b0, 32'h0, rd, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL post_en: got %h want 00000000", rd); end
  endtask

  initial begin
    test_reset;
    test_out;
    test_debounce;
    test_irq;
    test_set_wins;
    test_bad_addr;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/iomem_gpio_irq.md
Name: iomem_gpio_irq

Overview:
- Parametrised GPIO peripheral for the picosoc_noflash iomem bus. Generalises the inline switch/LED register into a standalone block.
- Provides configurable output width, input width and base address.
- Inputs pass through a two-flop synchroniser and an optional debouncer, then feed per-bit rising/falling edge interrupt capture.
- Drives one level interrupt into a spare soc irq line (irq_5..irq_7).

Parameters:
- N_OUT, 16, output bit count (1..32)
- N_IN, 16, input bit count (1..32)
- BASE_HI, 8'h03, required value of iomem_addr[31:24]
- DEB_DIV, 50000, debounce sample period in clk cycles; 0 = debounce bypassed
- DEB_W, 16, prescaler counter width; must satisfy 2**DEB_W > DEB_DIV

Ports:
- clk  in  1  system clock (BUFG output)
- reset  in  1  asynchronous, active-high reset
- iomem_valid  in  1  bus request
- iomem_ready  out  1  one-cycle acknowledge
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- gpio_in  in  N_IN  asynchronous external inputs (switches)
- gpio_out  out  N_OUT  registered outputs (LEDs)
- irq  out  1  level interrupt: |(irq_status & irq_en)

Behaviour:
- Reset (async assert, sync deassert expected from top) clears iomem_ready, iomem_rdata, gpio_out, irq_en, irq_rise, irq_fall, irq_status, synchroniser flops, debounced state and prescaler. irq=0.
- Register map, selected by addr[4:2]; addr[1:0] ignored:
  - 0 OUT  RW  bits [N_OUT-1:0]
  - 1 IN  RO  debounced input
  - 2 OUT_SET  WO  1 bits set gpio_out
  - 3 OUT_CLR  WO  1 bits clear gpio_out
  - 4 IRQ_RISE  RW  per-bit rising-edge enable
  - 5 IRQ_FALL  RW  per-bit falling-edge enable
  - 6 IRQ_STATUS  RW1C  sticky per-bit event flags
  - 7 IRQ_EN  RW  per-bit interrupt mask
- Reads of WO registers return 0. Unimplemented upper bits read 0 and ignore writes.
- Handshake:
  - Access is taken when iomem_valid && !iomem_ready && addr[31:24]==BASE_HI.
  - iomem_ready asserts the next cycle for exactly one cycle; iomem_rdata is registered in the same edge.
  - Non-matching address: never acked; ready stays 0.
  - Back-to-back requests are therefore at most one every 2 cycles.
- Writes honour wstrb per byte on all writable registers, including OUT_SET, OUT_CLR and IRQ_STATUS W1C.
- Write latency: the register reflects new data on the edge that raises iomem_ready.
- Input path: gpio_in -> 2-flop sync -> debounce -> in_db.
  - DEB_DIV=0: in_db = sync output.
  - Otherwise the prescaler emits a tick every DEB_DIV cycles. On a tick, each bit samples sync; in_db updates a bit only when two consecutive tick samples agree.
- Edge detect: prev_db register; rise = in_db & ~prev_db, fall = ~in_db & prev_db.
  - irq_status[i] is set when (rise[i] & irq_rise[i]) | (fall[i] & irq_fall[i]).
- Simultaneous event set and W1C clear on the same bit in the same cycle: set wins (no event lost).
- irq is combinational from registered status and enable, so it has no extra latency beyond the status flop.
- Async reset mid-transaction: ready drops immediately, no ack is issued, state returns to reset values. The CPU is reset by the same source.

Decomposition:
- Shared package gpio_pkg holds:
  - register offset constants REG_OUT..REG_EN (3-bit)
  - register-count localparam
  - default BASE_HI
- One sub-module, gpio_in_cond, instanced once with width N_IN: contains the synchroniser, prescaler, debouncer and edge detector, and outputs in_db, rise and fall.
- The top level contains the bus decode and register file.

Test Plan:
- Reset then read OUT and IN with gpio_in=16'h0000 -> rdata 0, gpio_out 0, irq 0; ready high exactly 1 cycle after valid.
- Write OUT=32'hFFFF_A5A5 with wstrb=4'b0001, then OUT_SET 0x0100, then OUT_CLR 0x0001 -> gpio_out 16'h01A4; upper bits read 0.
- DEB_DIV=4: pulse gpio_in[3] high for 3 cycles -> in_db unchanged. Hold it high for 20 cycles -> IN reads 0x0008 no earlier than 2 ticks plus 2 sync cycles after the change.
- IRQ_RISE=0x8, IRQ_EN=0x8, raise gpio_in[3] -> irq_status=0x8, irq=1. Write IRQ_STATUS=0x8 -> irq=0 the next cycle. Repeat with IRQ_FALL on a falling edge.
- Force an edge event in the same cycle as the W1C write to that bit -> status bit remains 1.
- Access with addr=32'h0400_0000 and valid held 5 cycles -> ready never asserts. Assert reset during a pending ack -> ready=0 immediately and all registers read reset values after release.
